// File: rtl/poly_mult_reduce_out.sv
// poly_mult_reduce_out
// Reads the 2N-bit product RAM of the poly_mult core one word at a time and
// folds it modulo x^N - 1 (reduced = lo ^ (hi >> N)). The N-bit result is
// packed four words per 128-bit beat onto a valid/ready stream.
//
// Optional build macro: POLY_RED_POPCOUNT_EN adds hw_o, the Hamming weight
// of the reduced polynomial. It is final from the done_o pulse until the
// next start.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        one-cycle pulse: the product RAM is complete
//   rd_dout_o      result RAM read enable
//   addr_result_o  result RAM word address
//   dout_i         result RAM read data, valid one cycle after rd_dout_o
//   out_data_o     packed beat; word k is in bits [32k+31:32k]
//   out_valid_o    beat valid
//   out_last_o     final beat
//   out_ready_i    downstream accept
//   busy_o         run in progress
//   done_o         one-cycle pulse after the last beat is accepted
//   hw_o           (POLY_RED_POPCOUNT_EN) popcount of the reduced polynomial
module poly_mult_reduce_out #(
  parameter int unsigned N          = 17669,
  parameter int unsigned RAMWIDTH   = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned OUTW       = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  rd_dout_o,
  output logic [ADDR_WIDTH-1:0] addr_result_o,
  input  logic [RAMWIDTH-1:0]   dout_i,
  output logic [OUTW-1:0]       out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
`ifdef POLY_RED_POPCOUNT_EN
  ,
  output logic [14:0]           hw_o
`endif
);

  localparam int unsigned NW      = (N + RAMWIDTH - 1) / RAMWIDTH;
  localparam int unsigned HI_BASE = N / RAMWIDTH;
  localparam int unsigned S       = N % RAMWIDTH;
  localparam int unsigned IW      = $clog2(NW + 1);
  localparam int unsigned SLOTS   = OUTW / RAMWIDTH;
  localparam int unsigned SW      = $clog2(SLOTS);
  // Top reduced word only carries bits below N.
  localparam logic [RAMWIDTH-1:0] LAST_MASK =
    (S == 0) ? '1 : RAMWIDTH'((64'd1 << S) - 64'd1);

  typedef enum logic [2:0] {
    IDLE, PRIME, PRIME_W, RD_LO, RD_HI, CALC, EMIT, DONE
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [RAMWIDTH-1:0]   lo;
  logic [RAMWIDTH-1:0]   prev;
  logic [2*RAMWIDTH-1:0] pair_c;
  logic [RAMWIDTH-1:0]   hi_al_c;
  logic [RAMWIDTH-1:0]   red_c;
  logic                  last_word_c;

  // Reduced word: high half realigned across the word boundary at bit N.
  always_comb begin
    last_word_c = (idx == IW'(NW - 1));
    pair_c      = {dout_i, prev};
    hi_al_c     = RAMWIDTH'(pair_c >> S);
    red_c       = (lo ^ hi_al_c) & (last_word_c ? LAST_MASK : '1);
  end

  // Reader / packer sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      lo            <= '0;
      prev          <= '0;
      rd_dout_o     <= 1'b0;
      addr_result_o <= '0;
      out_data_o    <= '0;
      out_valid_o   <= 1'b0;
      out_last_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
`ifdef POLY_RED_POPCOUNT_EN
      hw_o          <= '0;
`endif
    end else begin
      rd_dout_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state         <= PRIME;
            idx           <= '0;
            out_data_o    <= '0;
            busy_o        <= 1'b1;
            rd_dout_o     <= 1'b1;
            addr_result_o <= ADDR_WIDTH'(HI_BASE);
`ifdef POLY_RED_POPCOUNT_EN
            hw_o          <= '0;
`endif
          end
        end
        PRIME: state <= PRIME_W;
        PRIME_W: begin
          prev          <= dout_i;
          state         <= RD_LO;
          rd_dout_o     <= 1'b1;
          addr_result_o <= ADDR_WIDTH'(idx);
        end
        RD_LO: begin
          state         <= RD_HI;
          rd_dout_o     <= 1'b1;
          addr_result_o <= ADDR_WIDTH'(HI_BASE + 1) + ADDR_WIDTH'(idx);
        end
        RD_HI: begin
          lo    <= dout_i;
          state <= CALC;
        end
        CALC: begin
          out_data_o[RAMWIDTH*int'(idx[SW-1:0]) +: RAMWIDTH] <= red_c;
          prev <= dout_i;
          idx  <= idx + IW'(1);
`ifdef POLY_RED_POPCOUNT_EN
          hw_o <= hw_o + 15'($countones(red_c));
`endif
          if (idx[SW-1:0] == SW'(SLOTS - 1) || last_word_c) begin
            state       <= EMIT;
            out_valid_o <= 1'b1;
            out_last_o  <= last_word_c;
          end else begin
            state         <= RD_LO;
            rd_dout_o     <= 1'b1;
            addr_result_o <= ADDR_WIDTH'(idx + IW'(1));
          end
        end
        EMIT: begin
          // Reader stays parked here until the beat is taken.
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            if (out_last_o) begin
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state         <= RD_LO;
              rd_dout_o     <= 1'b1;
              addr_result_o <= ADDR_WIDTH'(idx);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_mult_reduce_out.sv
// Bench for poly_mult_reduce_out: a RAM model serves the product, and the
// expected stream is derived bit by bit as reduced[k] = P[k] ^ P[k+N].
module tb_poly_mult_reduce_out;

  localparam int N      = 17669;
  localparam int NWORDS = 1106;
  localparam int NBEAT  = 139;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         out_ready_i = 1'b1;
  logic         rd_dout_o;
  logic [10:0]  addr_result_o;
  logic [31:0]  dout_i = '0;
  logic [127:0] out_data_o;
  logic         out_valid_o, out_last_o, busy_o, done_o;
`ifdef POLY_RED_POPCOUNT_EN
  logic [14:0]  hw_o;
`endif

  poly_mult_reduce_out dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .rd_dout_o(rd_dout_o), .addr_result_o(addr_result_o), .dout_i(dout_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o)
`ifdef POLY_RED_POPCOUNT_EN
    , .hw_o(hw_o)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0]  mem   [0:NWORDS-1];
  logic [127:0] exp_b [0:NBEAT-1];
  logic [127:0] got_b [0:NBEAT-1];
  int           exp_hw;

  int n_checks = 0;
  int n_fail   = 0;

  // Product RAM with one-cycle read latency.
  always @(posedge clk) if (rd_dout_o) dout_i <= mem[addr_result_o];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic pbit(input int j);
    if (j >= NWORDS * 32) return 1'b0;
    return mem[j / 32][j % 32];
  endfunction

  // Reference: reduced bit k is product bit k XOR product bit k+N.
  task automatic build_model();
    logic b;
    for (int m = 0; m < NBEAT; m++) exp_b[m] = '0;
    exp_hw = 0;
    for (int k = 0; k < N; k++) begin
      b = pbit(k) ^ pbit(k + N);
      exp_b[k / 128][k % 128] = b;
      if (b) exp_hw++;
    end
  endtask

  task automatic clear_mem();
    for (int w = 0; w < NWORDS; w++) mem[w] = '0;
  endtask

  task automatic fill_rand();
    for (int w = 0; w < NWORDS; w++) mem[w] = $urandom;
  endtask

  // Ready driver: always-ready, random, or a 10-cycle hold on one beat.
  bit rand_ready = 1'b0;
  int hold_beat  = -1;
  int hold_cnt   = 0;
  bit hold_done  = 1'b0;
  int beat_idx   = 0;

  always @(posedge clk) begin
    #1;
    if (hold_cnt != 0) begin
      out_ready_i = 1'b0;
      hold_cnt--;
    end else if (hold_beat >= 0 && !hold_done && out_valid_o && beat_idx == hold_beat) begin
      out_ready_i = 1'b0;
      hold_cnt    = 9;
      hold_done   = 1'b1;
    end else begin
      out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Compare process: every negedge while a run is active.
  bit           active = 1'b0;
  int           cyc = 0;
  int           last_acc = -10;
  int           done_cnt = 0;
  int           stall_cycles = 0;
  bit           stall_prev = 1'b0;
  bit           done_prev = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    cyc++;
    if (active) begin
      if (out_valid_o) begin
        chk("no_read_while_pending", rd_dout_o, 0);
        chk("busy_during_beat", busy_o, 1);
        if (stall_prev) begin
          chk("stall_data_stable", out_data_o, prev_data);
          chk("stall_last_stable", out_last_o, prev_last);
        end
        if (out_ready_i) begin
          if (beat_idx < NBEAT) begin
            chk($sformatf("beat%0d_data", beat_idx), out_data_o, exp_b[beat_idx]);
            chk($sformatf("beat%0d_last", beat_idx), out_last_o, (beat_idx == NBEAT - 1));
            got_b[beat_idx] = out_data_o;
          end else begin
            chk("beat_overrun", beat_idx, NBEAT - 1);
          end
          beat_idx++;
          last_acc   = cyc;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          prev_data  = out_data_o;
          prev_last  = out_last_o;
          stall_cycles++;
        end
      end else begin
        stall_prev = 1'b0;
      end
      if (done_o) begin
        chk("done_beat_count", beat_idx, NBEAT);
        chk("busy_low_at_done", busy_o, 0);
        chk("done_after_last", cyc, last_acc + 1);
        chk("done_one_cycle", done_prev, 0);
`ifdef POLY_RED_POPCOUNT_EN
        chk("hw_at_done", hw_o, exp_hw);
`endif
        done_cnt++;
      end
    end
    done_prev = done_o;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_data"},  out_data_o, 0);
    chk({tag, "_valid"}, out_valid_o, 0);
    chk({tag, "_last"},  out_last_o, 0);
    chk({tag, "_rd"},    rd_dout_o, 0);
    chk({tag, "_addr"},  addr_result_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
`ifdef POLY_RED_POPCOUNT_EN
    chk({tag, "_hw"},    hw_o, 0);
`endif
  endtask

  // One run: start, check first-beat latency, then wait for done or reset mid-stream.
  task automatic run(input bit extra_start, input int rst_at);
    int lat;
    int n;
    int d0;
    build_model();
    beat_idx     = 0;
    stall_cycles = 0;
    stall_prev   = 1'b0;
    hold_done    = 1'b0;
    d0           = done_cnt;
    active       = 1'b1;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_valid_latency", lat, 15);
    if (extra_start) begin
      repeat (30) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
    end
    if (rst_at >= 0) begin
      n = 0;
      while (beat_idx < rst_at && n < 10000) begin
        @(posedge clk);
        n++;
      end
      chk("reached_reset_beat", beat_idx, rst_at);
      #1 rst = 1'b1;
      active = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_zero("mid_reset");
      @(posedge clk);
    end else begin
      n = 0;
      while (done_cnt == d0 && n < 20000) begin
        @(posedge clk);
        n++;
      end
      chk("done_timeout", done_cnt, d0 + 1);
      @(negedge clk);
      active = 1'b0;
      chk("busy_idle_after_done", busy_o, 0);
      chk("done_dropped", done_o, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // All-zero product.
    run(1'b0, -1);
    chk("zero_beat0", got_b[0], 128'h0);
    chk("zero_beat138", got_b[138], 128'h0);

    // Product bit 0.
    clear_mem();
    mem[0] = 32'h1;
    run(1'b0, -1);
    chk("p0_beat0", got_b[0], 128'h1);
    chk("p0_beat1", got_b[1], 128'h0);

    // Product bit N folds to bit 0; bit N-2 stays in the top word.
    clear_mem();
    mem[552] = 32'h28;
    run(1'b0, -1);
    chk("pn_beat0", got_b[0], 128'h1);
    chk("pn_beat138", got_b[138], 128'h8);

    // Product bits 2N-10 and 2N-2 fold to N-10 and N-2.
    clear_mem();
    mem[1104] = 32'h0000_0101;
    run(1'b0, -1);
    chk("p2n_beat137_w3", got_b[137][127:96], 32'h0800_0000);
    chk("p2n_beat137_lo", got_b[137][95:0], 96'h0);
    chk("p2n_beat138", got_b[138], 128'h8);

    // Random product, random ready, second start while busy.
    fill_rand();
    rand_ready = 1'b1;
    run(1'b1, -1);

    // Ten-cycle hold on beat 5.
    fill_rand();
    rand_ready = 1'b0;
    hold_beat  = 5;
    run(1'b0, -1);
    chk("hold_stall_cycles", stall_cycles, 10);
    hold_beat = -1;

    // Reset during beat 40, then a fresh full run.
    fill_rand();
    rand_ready = 1'b1;
    run(1'b0, 40);
    fill_rand();
    run(1'b0, -1);

`ifdef POLY_RED_POPCOUNT_EN
    clear_mem();
    rand_ready = 1'b0;
    mem[0]   = 32'hFF;
    mem[552] = 32'h1E0;
    run(1'b0, -1);
    chk("pc_beat0", got_b[0], 128'hF0);
    chk("pc_hw_literal", hw_o, 15'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
